// File: rtl/nes_bus_pkg.sv
// Shared types for the cartridge PRG bus: initiator FSM state, command word and flag positions.
// Also holds the read-data priority used when sampling the bus on M2.
package nes_bus_pkg;

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} prg_bus_state_t;

    typedef struct packed {
        logic        write;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } prg_cmd_t;

    localparam int FLAG_PRG_BUS_WRITE = 1;

    // A mapper driving the data bus wins over memory; with neither, the CPU sees the last byte.
    function automatic logic [7:0] prg_read_select(
        input logic       bus_write,
        input logic       allow,
        input logic [7:0] dout,
        input logic [7:0] mem,
        input logic [7:0] open_bus
    );
        if (bus_write) begin
            return dout;
        end else if (allow) begin
            return mem;
        end
        return open_bus;
    endfunction

endpackage

// File: rtl/nes_prg_bus_initiator_if.sv
// Command/response stream plus the mapper-facing PRG bus of the initiator.
// master = initiator side, slave = engine and mapper side.
interface nes_prg_bus_initiator_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic        rsp_valid;
    logic [7:0]  rsp_rdata;
    logic        ce;
    logic [15:0] prg_ain;
    logic        prg_read;
    logic        prg_write;
    logic [7:0]  prg_din;
    logic [7:0]  prg_dout;
    logic        prg_allow;
    logic [15:0] flags_out;
    logic [7:0]  mem_rdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  prg_dout, prg_allow, flags_out, mem_rdata,
        output cmd_ready, rsp_valid, rsp_rdata,
        output ce, prg_ain, prg_read, prg_write, prg_din
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output prg_dout, prg_allow, flags_out, mem_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata,
        input  ce, prg_ain, prg_read, prg_write, prg_din
    );

endinterface

// File: rtl/nes_m2_phase_gen.sv
// Free-running CPU-cycle phase counter; ce_o is the one-clk M2 strobe on the last phase.
// No backpressure: it keeps counting while idle because mappers count M2.
module nes_m2_phase_gen #(
    parameter int CE_DIV = 12
) (
    input  logic clk,
    input  logic reset_n,
    output logic last_phase_o,
    output logic ce_o
);

    localparam int PH_W = $clog2(CE_DIV);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CE_DIV - 1);

    logic [PH_W-1:0] ph_q;
    logic [PH_W-1:0] ph_d;

    assign last_phase_o = (ph_q == PH_LAST);
    // Gated so a reset landing on the last phase never shows the mapper an M2 edge.
    assign ce_o         = last_phase_o & reset_n;

    always_comb begin
        ph_d = last_phase_o ? '0 : ph_q + PH_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ph_q <= '0;
        end else begin
            ph_q <= ph_d;
        end
    end

endmodule

// File: rtl/nes_prg_bus_initiator.sv
// Turns single-byte read/write commands into M2-paced PRG bus cycles; read data returns 1 clk after ce.
// One-entry slot: cmd_ready drops while a command waits for its CPU cycle, so one command per CE_DIV clks.
module nes_prg_bus_initiator
    import nes_bus_pkg::*;
#(
    parameter int CE_DIV = 12
) (
    input logic                      clk,
    input logic                      reset_n,
    nes_prg_bus_initiator_if.master  bus
);

    logic           last_phase;
    logic           ce_w;

    prg_bus_state_t state_q, state_d;
    logic           slot_vld_q, slot_vld_d;
    prg_cmd_t       slot_q, slot_d;
    logic [15:0]    ain_q, ain_d;
    logic [7:0]     din_q, din_d;
    logic           rd_q, rd_d;
    logic           wr_q, wr_d;
    logic [7:0]     open_bus_q, open_bus_d;
    logic           rsp_vld_q, rsp_vld_d;
    logic [7:0]     rsp_dat_q, rsp_dat_d;

    logic           accept;
    logic           launch;
    logic           complete;
    logic [7:0]     rd_byte;
    logic           unused_flags;

    nes_m2_phase_gen #(
        .CE_DIV (CE_DIV)
    ) u_phase (
        .clk          (clk),
        .reset_n      (reset_n),
        .last_phase_o (last_phase),
        .ce_o         (ce_w)
    );

    assign accept   = bus.cmd_valid & ~slot_vld_q;
    // The slot is handed to the bus at the cycle boundary, freeing it for the next command.
    assign launch   = last_phase & slot_vld_q;
    assign complete = last_phase & (state_q == ACTIVE);

    assign rd_byte      = prg_read_select(bus.flags_out[FLAG_PRG_BUS_WRITE], bus.prg_allow,
                                          bus.prg_dout, bus.mem_rdata, open_bus_q);
    assign unused_flags = ^{bus.flags_out[15:2], bus.flags_out[0]};

    always_comb begin
        state_d    = state_q;
        slot_vld_d = slot_vld_q;
        slot_d     = slot_q;
        ain_d      = ain_q;
        din_d      = din_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        open_bus_d = open_bus_q;
        rsp_vld_d  = 1'b0;
        rsp_dat_d  = rsp_dat_q;

        if (complete) begin
            if (rd_q) begin
                rsp_vld_d  = 1'b1;
                rsp_dat_d  = rd_byte;
                open_bus_d = rd_byte;
            end else begin
                open_bus_d = din_q;
            end
        end

        if (accept) begin
            slot_vld_d = 1'b1;
            slot_d     = '{write: bus.cmd_write, addr: bus.cmd_addr, wdata: bus.cmd_wdata};
        end

        // Bus strobes and address only move on the CE_DIV-1 -> 0 boundary.
        if (last_phase) begin
            state_d = slot_vld_q ? ACTIVE : IDLE;
            rd_d    = launch & ~slot_q.write;
            wr_d    = launch & slot_q.write;
            if (launch) begin
                ain_d      = slot_q.addr;
                din_d      = slot_q.wdata;
                slot_vld_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            slot_vld_q <= 1'b0;
            slot_q     <= '0;
            ain_q      <= 16'h0000;
            din_q      <= 8'h00;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            open_bus_q <= 8'h00;
            rsp_vld_q  <= 1'b0;
            rsp_dat_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            slot_vld_q <= slot_vld_d;
            slot_q     <= slot_d;
            ain_q      <= ain_d;
            din_q      <= din_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            open_bus_q <= open_bus_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_dat_q  <= rsp_dat_d;
        end
    end

    assign bus.cmd_ready = ~slot_vld_q;
    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_rdata = rsp_dat_q;
    assign bus.ce        = ce_w;
    assign bus.prg_ain   = ain_q;
    assign bus.prg_din   = din_q;
    assign bus.prg_read  = rd_q;
    assign bus.prg_write = wr_q;

endmodule

// File: tb/tb_nes_prg_bus_initiator.sv
// Bench for nes_prg_bus_initiator: scoreboarded reads, a small Sachen8259 register model and bus-run tracking.
module tb_nes_prg_bus_initiator;

    localparam int CE_DIV = 12;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    nes_prg_bus_initiator_if bus ();

    nes_prg_bus_initiator #(.CE_DIV(CE_DIV)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    int         run_len_q[$];
    int         run_ce_q[$];
    int         ce_cyc_q[$];
    int         run_len = 0;
    int         run_ce = 0;
    int         rsp_cnt = 0;
    int         cyc = 0;

    logic       own_en;
    logic [7:0] own_dat;
    logic [7:0] mem_key;
    logic       allow_force;

    logic [2:0] sachen_idx;
    logic [7:0] sachen_reg[8];

    function automatic logic [7:0] mem_model(input logic [15:0] a, input logic [7:0] k);
        return a[7:0] ^ a[15:8] ^ k;
    endfunction

    assign bus.flags_out = {14'h0000, own_en, 1'b0};
    assign bus.prg_dout  = own_dat;
    assign bus.prg_allow = allow_force | bus.prg_ain[15];
    assign bus.mem_rdata = mem_model(bus.prg_ain, mem_key);

    // Sachen8259 subset: $4100 selects a register, $4101 writes it; register 5 is the PRG bank.
    always @(posedge clk) begin
        if (!reset_n) begin
            sachen_idx <= 3'd0;
            for (int i = 0; i < 8; i++) sachen_reg[i] <= 8'h00;
        end else if (bus.ce && bus.prg_write) begin
            if (bus.prg_ain == 16'h4100) sachen_idx <= bus.prg_din[2:0];
            else if (bus.prg_ain == 16'h4101) sachen_reg[sachen_idx] <= bus.prg_din;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset_n) begin
            run_len <= 0;
            run_ce  <= 0;
        end else if (bus.prg_read || bus.prg_write) begin
            run_len <= run_len + 1;
            run_ce  <= run_ce + (bus.ce ? 1 : 0);
        end else if (run_len != 0) begin
            run_len_q.push_back(run_len);
            run_ce_q.push_back(run_ce);
            run_len <= 0;
            run_ce  <= 0;
        end
        if (bus.ce) ce_cyc_q.push_back(cyc);
        if (bus.rsp_valid) begin
            rsp_cnt <= rsp_cnt + 1;
            got_q.push_back(bus.rsp_rdata);
            got_cyc_q.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers a command and returns #1 after the clk edge that accepted it; cmd_valid stays high.
    task automatic push_cmd(input logic w, input logic [15:0] a, input logic [7:0] d);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        while (!bus.cmd_ready && n < 4 * CE_DIV) begin
            tick();
            n++;
        end
        if (!bus.cmd_ready) begin
            vectors++;
            miscompares++;
            $display("FAIL cmd_accept: cmd_ready=%0b after %0d clks, required 1", bus.cmd_ready, n);
        end
        tick();
    endtask

    task automatic wait_rsp(input int need, output bit ok);
        int n = 0;
        while (got_q.size() < need && n < 6 * CE_DIV) begin
            tick();
            n++;
        end
        ok = (got_q.size() >= need);
    endtask

    task automatic drain();
        bus.cmd_valid = 1'b0;
        repeat (3 * CE_DIV) tick();
        run_len_q.delete();
        run_ce_q.delete();
        got_q.delete();
        got_cyc_q.delete();
        ce_cyc_q.delete();
    endtask

    task automatic test_reset();
        int n;
        reset_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 16'h0000;
        bus.cmd_wdata = 8'h00;
        own_en        = 1'b0;
        own_dat       = 8'h00;
        mem_key       = 8'h00;
        allow_force   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (bus.ce !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ce[%0d]: ce=%b required 0", i, bus.ce);
            end
        end
        vectors++;
        if (bus.cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_cmd_ready: got %b required 1", bus.cmd_ready);
        end
        vectors++;
        if (bus.rsp_valid !== 1'b0 || bus.rsp_rdata !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_rsp: valid=%b rdata=%h required 0/00", bus.rsp_valid, bus.rsp_rdata);
        end
        vectors++;
        if (bus.prg_ain !== 16'h0000 || bus.prg_din !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_bus: ain=%h din=%h required 0000/00", bus.prg_ain, bus.prg_din);
        end
        vectors++;
        if (bus.prg_read !== 1'b0 || bus.prg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: read=%b write=%b required 0/0", bus.prg_read, bus.prg_write);
        end
        reset_n = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!bus.ce && n < 2 * CE_DIV);
        #1;
        vectors++;
        if (n != CE_DIV) begin
            miscompares++;
            $display("FAIL first_ce: ce sampled on clk %0d after release, required %0d", n, CE_DIV);
        end
    endtask

    task automatic test_single_write();
        int rsp0 = rsp_cnt;
        int l;
        int c;
        logic [15:0] addrs[2];
        addrs[0] = 16'h4100;
        addrs[1] = 16'h4101;
        drain();
        rsp0 = rsp_cnt;
        for (int i = 0; i < 2; i++) begin
            push_cmd(1'b1, addrs[i], 8'h05);
            bus.cmd_valid = 1'b0;
            repeat (2 * CE_DIV + 2) tick();
            l = (run_len_q.size() > 0) ? run_len_q.pop_front() : -1;
            c = (run_ce_q.size() > 0) ? run_ce_q.pop_front() : -1;
            vectors++;
            if (l != CE_DIV || c != 1) begin
                miscompares++;
                $display("FAIL write_run[%h]: prg_write clks=%0d ce=%0d required %0d/1", addrs[i], l, c, CE_DIV);
            end
        end
        vectors++;
        if (sachen_reg[5] !== 8'h05 || sachen_idx !== 3'd5) begin
            miscompares++;
            $display("FAIL sachen_bank: reg5=%h idx=%0d required 05/5", sachen_reg[5], sachen_idx);
        end
        vectors++;
        if (bus.prg_ain !== 16'h4101 || bus.prg_din !== 8'h05 || bus.prg_write !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_hold: ain=%h din=%h write=%b required 4101/05/0", bus.prg_ain, bus.prg_din, bus.prg_write);
        end
        vectors++;
        if (rsp_cnt != rsp0) begin
            miscompares++;
            $display("FAIL write_no_rsp: %0d responses, required 0", rsp_cnt - rsp0);
        end
    endtask

    task automatic test_protection_read();
        bit ok;
        int t0;
        int lat;
        logic [7:0] e;
        logic [7:0] g;
        drain();
        own_en      = 1'b1;
        own_dat     = 8'h3A;
        allow_force = 1'b1;
        mem_key     = 8'h14;
        exp_q.push_back(8'h3A);
        push_cmd(1'b0, 16'h4100, 8'h00);
        t0 = cyc;
        bus.cmd_valid = 1'b0;
        e = exp_q.pop_front();
        wait_rsp(1, ok);
        g   = ok ? got_q.pop_front() : 8'hxx;
        lat = ok ? got_cyc_q.pop_front() - t0 : -1;
        vectors++;
        if (!ok || g !== e) begin
            miscompares++;
            $display("FAIL prot_read: got %h required %h", g, e);
        end
        vectors++;
        if (lat < CE_DIV + 1 || lat > 2 * CE_DIV + 1) begin
            miscompares++;
            $display("FAIL prot_latency: %0d clks, required %0d..%0d", lat, CE_DIV + 1, 2 * CE_DIV + 1);
        end
        tick();
        vectors++;
        if (bus.prg_ain !== 16'h4100 || bus.prg_read !== 1'b0) begin
            miscompares++;
            $display("FAIL prot_after: ain=%h read=%b required 4100/0", bus.prg_ain, bus.prg_read);
        end
        own_en      = 1'b0;
        allow_force = 1'b0;
    endtask

    task automatic test_reads();
        bit ok;
        logic [7:0] e;
        logic [7:0] g;
        int k = 0;
        drain();
        mem_key = 8'h29;
        exp_q.push_back(8'hA9);
        push_cmd(1'b0, 16'h8000, 8'h00);
        exp_q.push_back(8'hA9);
        push_cmd(1'b0, 16'h5000, 8'h00);
        push_cmd(1'b1, 16'h5000, 8'h6C);
        exp_q.push_back(8'h6C);
        push_cmd(1'b0, 16'h5001, 8'h00);
        bus.cmd_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_rsp(1, ok);
            g = ok ? got_q.pop_front() : 8'hxx;
            vectors++;
            if (!ok || g !== e) begin
                miscompares++;
                $display("FAIL read_seq[%0d]: got %h required %h", k, g, e);
            end
            k++;
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [7:0] e;
        logic [7:0] g;
        int k = 0;
        int l;
        int c;
        int bad_gap = 0;
        drain();
        mem_key = 8'h11;
        exp_q.push_back(mem_model(16'h8001, 8'h11));
        push_cmd(1'b0, 16'h8001, 8'h00);
        push_cmd(1'b1, 16'h6000, 8'h33);
        exp_q.push_back(mem_model(16'h8002, 8'h11));
        push_cmd(1'b0, 16'h8002, 8'h00);
        exp_q.push_back(mem_model(16'h8002, 8'h11));
        push_cmd(1'b0, 16'h5003, 8'h00);
        bus.cmd_valid = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            wait_rsp(1, ok);
            g = ok ? got_q.pop_front() : 8'hxx;
            vectors++;
            if (!ok || g !== e) begin
                miscompares++;
                $display("FAIL b2b_rsp[%0d]: got %h required %h", k, g, e);
            end
            k++;
        end
        repeat (3) tick();
        l = (run_len_q.size() > 0) ? run_len_q.pop_front() : -1;
        c = (run_ce_q.size() > 0) ? run_ce_q.pop_front() : -1;
        vectors++;
        if (l != 4 * CE_DIV || c != 4) begin
            miscompares++;
            $display("FAIL b2b_run: busy clks=%0d ce=%0d required %0d/4", l, c, 4 * CE_DIV);
        end
        for (int i = 1; i < ce_cyc_q.size(); i++) begin
            if (ce_cyc_q[i] - ce_cyc_q[i-1] != CE_DIV) bad_gap++;
        end
        vectors++;
        if (bad_gap != 0 || ce_cyc_q.size() < 5) begin
            miscompares++;
            $display("FAIL b2b_ce_spacing: %0d bad gaps over %0d ce, required 0 over >=5", bad_gap, ce_cyc_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int rsp0;
        int n = 0;
        bit ok;
        logic [7:0] e;
        logic [7:0] g;
        drain();
        rsp0 = rsp_cnt;
        push_cmd(1'b0, 16'h8003, 8'h00);
        bus.cmd_valid = 1'b0;
        while (!bus.prg_read && n < 2 * CE_DIV) begin
            tick();
            n++;
        end
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        vectors++;
        if (bus.cmd_ready !== 1'b1 || bus.prg_read !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_state: cmd_ready=%b read=%b required 1/0", bus.cmd_ready, bus.prg_read);
        end
        reset_n = 1'b1;
        repeat (3 * CE_DIV) tick();
        vectors++;
        if (rsp_cnt != rsp0) begin
            miscompares++;
            $display("FAIL midreset_no_rsp: %0d responses, required 0", rsp_cnt - rsp0);
        end
        n = 0;
        while (!bus.ce && n < 2 * CE_DIV) begin
            tick();
            n++;
        end
        #1;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (bus.ce !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_clk_ce: ce=%b required 0", bus.ce);
        end
        tick();
        reset_n = 1'b1;
        got_q.delete();
        exp_q.push_back(mem_model(16'h8004, mem_key));
        push_cmd(1'b0, 16'h8004, 8'h00);
        bus.cmd_valid = 1'b0;
        e = exp_q.pop_front();
        wait_rsp(1, ok);
        g = ok ? got_q.pop_front() : 8'hxx;
        vectors++;
        if (!ok || g !== e) begin
            miscompares++;
            $display("FAIL post_reset_read: got %h required %h", g, e);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_protection_read();
        test_reads();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nes_prg_bus_initiator.md
# nes_prg_bus_initiator

CPU-side initiator for the cartridge PRG bus that the mapper modules respond to. It turns a valid/ready command stream of single-byte reads and writes into M2-paced bus cycles: it generates `ce`, drives `prg_ain`, `prg_read`, `prg_write` and `prg_din`, and returns read data with the mapper's own-data override applied. It sits between a debug/cheat/loader engine and the shared mapper bus, and exercises mapper register files and protection ports exactly as the 6502 would.

## Interface
- `CE_DIV`, default 12: `clk` cycles per CPU cycle. Legal range ≥ 3.
- `clk` in 1: system clock.
- `reset_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: the command slot is empty.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in 16: CPU address.
- `cmd_wdata` in 8: write data.
- `rsp_valid` out 1: one-clk pulse carrying the result of a read.
- `rsp_rdata` out 8: read result.
- `ce` out 1: one-clk M2 strobe per CPU cycle.
- `prg_ain` out 16: address to the mapper.
- `prg_read` out 1: read cycle in progress.
- `prg_write` out 1: write cycle in progress.
- `prg_din` out 8: write data to the mapper.
- `prg_dout` in 8: mapper-driven data.
- `prg_allow` in 1: ROM/RAM access permitted.
- `flags_out` in 16: mapper flags; bit 1 = `prg_bus_write` (mapper owns the data bus).
- `mem_rdata` in 8: memory data at the mapper's `prg_aout`.

## Operation
- **Phase counter** `ph`, width `$clog2(CE_DIV)`.
  - Free-runs 0..`CE_DIV`-1, then wraps to 0.
  - `ce` = 1 exactly when `ph` == `CE_DIV`-1, including when idle, because mappers count M2.
- **Command slot.** One entry, holding addr, wdata and write.
  - `cmd_ready` = slot empty.
  - Handshake: `cmd_valid & cmd_ready` loads the slot.
- **FSM `IDLE`.**
  - Stays here while the slot is empty or `ph` != `CE_DIV`-1.
  - When the slot is full and `ph` == `CE_DIV`-1: go to `ACTIVE`. `prg_ain` takes the slot address, `prg_din` takes the slot wdata, and `prg_read`/`prg_write` are set from the write bit.
  - A command loaded in the same clk as `ph` == `CE_DIV`-1 waits one full CPU cycle.
- **FSM `ACTIVE`.** Drives the bus for `ph` 0..`CE_DIV`-1 of one CPU cycle.
  - On the clk where `ce` = 1, the mapper samples the write. The slot empties and the state returns to `IDLE`.
  - If the slot is refilled in the same clk and `ph` == `CE_DIV`-1, go straight back to `ACTIVE` (back-to-back cycles, no idle gap).
- **Read data select**, sampled on the `ce` clk of a read:
  - `flags_out[1]` → `prg_dout`
  - else `prg_allow` → `mem_rdata`
  - else → `open_bus`
- **Open bus register** `open_bus`: updated with the byte transferred on every read or write at `ce`.
- **Idle bus state.**
  - `prg_read` = `prg_write` = 0.
  - `prg_ain` and `prg_din` hold their last values.
- **Responses.**
  - Reads: `rsp_valid` pulses 1 clk after `ce`, with the sampled byte.
  - Writes: produce no response.
  - Responses come back in command order.

## Timing
- **Reset values** (`reset_n` = 0 at a `clk` edge): `ph`=0, `ce`=0, `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `prg_ain`=16'h0000, `prg_din`=0, `prg_read`=0, `prg_write`=0, `open_bus`=0, FSM=`IDLE`.
- **Reset mid-cycle.** The command in flight is dropped with no response. `ce` does not fire in the reset clk.
- **Latency** from acceptance to `rsp_valid`: between `CE_DIV`+1 and 2·`CE_DIV`+1 clks, depending on `ph` at acceptance.
- **Throughput:** one command per `CE_DIV` clks when the next command is presented before `ph` == `CE_DIV`-1.
- **Input stability:** `flags_out`, `prg_allow`, `prg_dout` and `mem_rdata` are combinational from the mapper and must be stable on the `ce` clk. No registering on input.
- **Address changes** occur only on the transition `ph` `CE_DIV`-1 → 0, so mappers see a stable address for the whole cycle.

## Structure
- Shared package `nes_bus_pkg`:
  - `typedef enum logic {IDLE, ACTIVE} prg_bus_state_t`
  - `typedef struct packed {logic write; logic [15:0] addr; logic [7:0] wdata;} prg_cmd_t`
  - `localparam int FLAG_PRG_BUS_WRITE = 1`
- One sub-module: `nes_m2_phase_gen` (`CE_DIV` counter plus the `ce` and `last_phase` outputs). The rest lives in one module.

## Test plan
- **Reset.** Hold `reset_n`=0 for 3 clks. All outputs match the reset values; `ce` stays 0. Release: the first `ce` appears on clk `CE_DIV` after release.
- **Single write.** Write $4101←$05 to a Sachen8259 instance, preceded by a write $4100←$05. `prg_write`=1 for exactly 12 clks (`CE_DIV`=12) and one `ce`; the mapper's PRG bank becomes 5; no `rsp_valid`.
- **Protection read.** Read $4100 with `flags_out[1]`=1 and `prg_dout`=$3A. `rsp_rdata`=$3A, ignoring `mem_rdata`.
- **Normal and open-bus reads.**
  - Read $8000 with `prg_allow`=1 and `mem_rdata`=$A9 → $A9.
  - Read $5000 with `prg_allow`=0 and the override off → $A9 (open bus).
- **Back-to-back.** 4 commands with `cmd_valid` held high. `ce` pulses are spaced at exactly 12 clks with no idle gap; responses come back in order.
- **Reset mid-operation.** Pulse `reset_n`=0 at `ph`=5 of a read. No `rsp_valid` follows; `cmd_ready`=1 on the next clk.
